// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit.
//   - MDU op encodings (op port of mdu_iter)
//   - MDU FSM state type
//   - default datapath width
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement.
//   value_i  : input operand
//   neg_i    : 1 -> result_o = -value_i, 0 -> result_o = value_i
//   result_o : output
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] result_o
);

  // invert-and-add-one folded into one adder: (v ^ neg) + neg
  assign result_o = (value_i ^ {WIDTH{neg_i}}) + {{(WIDTH-1){1'b0}}, neg_i};

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) owning HI/LO.
// One result bit per cycle: IDLE -> RUN (WIDTH edges) -> FIX -> IDLE.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : launch (sampled in IDLE only), 00 MULTU 01 MULT 10 DIVU 11 DIV
//   src_a, src_b    : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we    : MTHI/MTLO strobes (IDLE only, start has priority)
//   wdata           : MTHI/MTLO data
//   busy            : state != IDLE
//   done            : registered one-cycle completion pulse
//   hi, lo          : HI/LO registers
// Optional build macro MDU_EARLY_OUT_EN: trivial multiplies (an operand is
// zero) and divide-by-zero skip RUN and finish in FIX directly.
module mdu_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // mult: {partial product, remaining multiplier bits}
  // div : {remainder, remaining dividend bits / quotient bits}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;    // result sign (operand signs differ)
  logic               rneg_q, rneg_d;  // remainder sign (dividend sign)
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     msum, dtop, ddiff;

  assign sa = op[0] & src_a[WIDTH-1];
  assign sb = op[0] & src_b[WIDTH-1];

  // |MIN| comes out as the unsigned value 2^(WIDTH-1), which the unsigned
  // datapath handles without overflow.
  mdu_negate #(.WIDTH(WIDTH))   u_abs_a (.value_i(src_a), .neg_i(sa), .result_o(a_abs));
  mdu_negate #(.WIDTH(WIDTH))   u_abs_b (.value_i(src_b), .neg_i(sb), .result_o(b_abs));
  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_p (.value_i(acc_q), .neg_i(neg_q), .result_o(prod_fix));
  mdu_negate #(.WIDTH(WIDTH))   u_fix_q (.value_i(acc_q[WIDTH-1:0]), .neg_i(neg_q),
                                         .result_o(quo_fix));
  mdu_negate #(.WIDTH(WIDTH))   u_fix_r (.value_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rneg_q),
                                         .result_o(rem_fix));

  // shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right
  assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  // restoring step: remainder shifted left with the next dividend bit in;
  // needs WIDTH+1 bits since the shifted remainder can exceed 2^WIDTH
  assign dtop  = acc_q[2*WIDTH-1:WIDTH-1];
  assign ddiff = dtop - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          acc_d   = {{WIDTH{1'b0}}, a_abs};
          b_d     = b_abs;
          cnt_d   = '0;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          state_d = RUN;
`ifdef MDU_EARLY_OUT_EN
          if (!op[1] && (src_a == '0 || src_b == '0)) begin
            acc_d   = '0;
            state_d = FIX;
          end else if (op[1] && src_b == '0) begin
            // remainder = |a| so the FIX sign fix-up returns src_a
            acc_d   = {a_abs, {WIDTH{1'b1}}};
            state_d = FIX;
          end
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          if (!ddiff[WIDTH]) acc_d = {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {dtop[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          // divisor zero: quotient is all ones regardless of signs;
          // remainder already equals |a| and picks up a's sign below
          lo_d = (b_q == '0) ? {WIDTH{1'b1}} : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core. Executes MULT, MULTU, DIV and DIVU, and owns the HI/LO registers.
- It is an EX-stage neighbour of the 2x1 operand/writeback muxes. Its hi/lo outputs feed the writeback-select mux used by MFHI/MFLO.
- The hazard unit uses its busy flag to stall the pipeline.
- Multi-cycle: one result bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- CNT_W, 6, iteration-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  launch operation. Sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  WIDTH  multiplicand or dividend (rs)
- src_b  in  WIDTH  multiplier or divisor (rt)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse, registered
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- A reset asserted mid-operation aborts the operation and applies the reset values at the next edge. No partial HI/LO update occurs.
- State IDLE:
  - start=1 at edge E0: latch op, |src_a|, |src_b| and the result sign flags (signed ops only; unsigned ops use operands raw).
  - Clear the accumulator and counter, then go to RUN.
  - hi_we/lo_we are honoured in IDLE only: HI<=wdata / LO<=wdata at the edge.
  - If start and hi_we/lo_we are high at the same edge, start wins and the write is dropped.
- State RUN (one result bit per edge, edges E1..E(WIDTH)):
  - Multiply: shift-add over the 2*WIDTH-bit product.
  - Divide: restoring divide. Shift remainder, trial-subtract divisor, set quotient bit if the difference is non-negative.
  - Counter increments each edge. At counter==WIDTH-1 go to FIX.
- State FIX (edge E(WIDTH+1)):
  - Apply sign correction (two's-complement negate).
  - Multiply: {HI,LO} <= product; negate if the operand signs differ.
  - Divide: LO <= quotient, negated if the signs differ. HI <= remainder, carrying the dividend's sign.
  - Set done=1, go to IDLE.
- Latency: start at E0 gives done high for exactly one cycle after E(WIDTH+1), i.e. E33 at WIDTH=32.
  - busy is high for WIDTH+1 cycles, from after E0 until E(WIDTH+1).
  - HI/LO hold their new values from E(WIDTH+1) onward.
- Ignored inputs:
  - start while busy is ignored; no queueing.
  - hi_we/lo_we while busy are ignored. The hazard unit must stall MTHI/MTLO while busy.
- Divide by zero (src_b==0): LO=all ones, HI=src_a unchanged. Same latency. Applies to both signed and unsigned divide.
- Signed overflow (DIV with src_a=0x80000000, src_b=0xFFFFFFFF): LO=0x80000000, HI=0.
- MIN operand: |0x80000000| is handled as unsigned 0x80000000. No overflow occurs in the iteration datapath.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- When defined: in IDLE, if start=1 and (multiply with src_a==0 or src_b==0) or (divide with src_b==0), skip RUN and go directly to FIX.
  - done pulses after E1 with the defined results: product 0, or the div-by-zero values above.
  - busy is high for one cycle only.
- When undefined: every operation takes the full WIDTH+1 cycles.

Decomposition:
- Shared package mips_pkg holds:
  - MDU op encodings: MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV.
  - State typedef: IDLE, RUN, FIX.
  - WIDTH default constant.
- Sub-module mdu_negate: combinational conditional two's-complement of a parameterised width. Inputs value and neg; output result.
  - Instantiated for operand absolute value and for FIX sign correction.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> done after E33; HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 33 cycles.
- DIVU 100/7 -> LO=14, HI=2. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, with a second start and lo_we pulsed at cycle 10 -> both ignored; HI=0xFFFFFFFE, LO=0x00000001; exactly one done pulse.
- Start MULTU 7*9, assert rst at cycle 15 -> next edge gives busy=0, done=0, hi=lo=0. A new start then completes normally with LO=63.
- With MDU_EARLY_OUT_EN: MULT 0*1234 -> done after E1, HI=LO=0, busy high one cycle. Without the macro -> done after E33.
